// File: rtl/vga_frame_reader.sv
// VGA scan-out master: walks the framebuffer through a memory read port and
// turns packed RGB332 words into a sync-aligned pixel stream for the display.
module vga_frame_reader #(
  parameter int BUS       = 32,
  parameter int FB_BASE   = 0,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enable,
  output logic [BUS-1:0] rd_addr,
  input  logic [BUS-1:0] rd_data,
  output logic [7:0]     pixel,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic           frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [BUS-1:0] BASE    = BUS'(FB_BASE);

  // Per-pixel control carried alongside the memory latency.
  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic       fs;
    logic [1:0] sel;
  } stage_t;

  localparam stage_t IDLE = '{act: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, sel: 2'd0};

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          h_wrap;
  logic          v_wrap;
  stage_t        s0;
  stage_t        s1;
  logic [7:0]    byte_sel;

  assign h_wrap = (hcnt == H_LAST);
  assign v_wrap = (vcnt == V_LAST);

  // Stage-0 view is forced idle while disabled, since the counters sit at (0,0).
  always_comb begin
    s0     = IDLE;
    s0.act = enable && (hcnt < H_ACT) && (vcnt < V_ACT);
    s0.hs  = !(enable && (hcnt >= HS_FIRST) && (hcnt <= HS_LAST));
    s0.vs  = !(enable && (vcnt >= VS_FIRST) && (vcnt <= VS_LAST));
    s0.fs  = enable && (hcnt == '0) && (vcnt == '0);
    s0.sel = hcnt[1:0];
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt    <= '0;
      vcnt    <= '0;
      rd_addr <= BASE;
    end else if (!enable) begin
      hcnt    <= '0;
      vcnt    <= '0;
      rd_addr <= BASE;
    end else begin
      hcnt <= h_wrap ? '0 : hcnt + 1'b1;
      if (h_wrap) vcnt <= v_wrap ? '0 : vcnt + 1'b1;
      // Lines are contiguous, so a running word counter replaces v*stride + h/4.
      if (h_wrap && v_wrap)
        rd_addr <= BASE;
      else if (s0.act && (hcnt[1:0] == 2'b11))
        rd_addr <= rd_addr + 1'b1;
    end
  end

  always_comb begin
    byte_sel = 8'h00;
    case (s1.sel)
      2'd0: byte_sel = rd_data[7:0];
      2'd1: byte_sel = rd_data[15:8];
      2'd2: byte_sel = rd_data[23:16];
      2'd3: byte_sel = rd_data[31:24];
      default: byte_sel = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1          <= IDLE;
      de          <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
      pixel       <= 8'h00;
    end else begin
      s1          <= s0;
      de          <= s1.act;
      hsync       <= s1.hs;
      vsync       <= s1.vs;
      frame_start <= s1.fs;
      pixel       <= s1.act ? byte_sel : 8'h00;
    end
  end

endmodule
